// File: rtl/fp_addsub_norm_pipe_if.sv
// fp_addsub_norm_pipe_if: handshake and data bundle between the align stage and the sign/pack stage.
interface fp_addsub_norm_pipe_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              sel2;
    logic [MANT_W-1:0] Shifted_val;
    logic [MANT_W-1:0] nonShifted_val;
    logic [EXP_W-1:0]  exponent_temp;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-2:0] fraction;
    logic [EXP_W-1:0]  exponent;
    logic              sign_flip;
    logic              zero;
    logic              overflow;
    logic              underflow;
    modport master (
        output in_valid, sel2, Shifted_val, nonShifted_val, exponent_temp, out_ready,
        input  in_ready, out_valid, fraction, exponent, sign_flip, zero, overflow, underflow
    );
    modport slave (
        input  in_valid, sel2, Shifted_val, nonShifted_val, exponent_temp, out_ready,
        output in_ready, out_valid, fraction, exponent, sign_flip, zero, overflow, underflow
    );
endinterface

// File: rtl/fp_addsub_norm_pipe.sv
// fp_addsub_norm_pipe: 3-stage mantissa add/subtract with carry/leading-zero normalisation.
module fp_addsub_norm_pipe #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input logic clk,
    input logic rst,
    fp_addsub_norm_pipe_if.slave bus
);
    localparam int LZ_W = $clog2(MANT_W + 1);
    localparam int CW   = EXP_W + LZ_W;
    logic              adv;
    logic              v1_q, v2_q, v3_q;
    logic [MANT_W:0]   m1_q, m1_d;
    logic [MANT_W-1:0] m2_q;
    logic              f1_q, f1_d, f2_q, c2_q;
    logic [EXP_W-1:0]  e1_q, e2_q;
    logic [LZ_W-1:0]   lz2_q, lz2_d;
    logic [MANT_W-2:0] frac_q, frac_d, shl;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [EXP_W:0]    inc;
    logic              flip_q, flip_d, zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d;
    assign adv          = !v3_q || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = v3_q;
    assign bus.fraction  = frac_q;
    assign bus.exponent  = exp_q;
    assign bus.sign_flip = flip_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    always_comb begin
        f1_d = bus.sel2 && (bus.Shifted_val > bus.nonShifted_val);
        m1_d = !bus.sel2 ? {1'b0, bus.nonShifted_val} + {1'b0, bus.Shifted_val}
             : f1_d ? {1'b0, bus.Shifted_val - bus.nonShifted_val}
             : {1'b0, bus.nonShifted_val - bus.Shifted_val};
    end
    // Highest set bit wins; an all-zero field yields MANT_W.
    always_comb begin
        lz2_d = LZ_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++)
            if (m1_q[i]) lz2_d = LZ_W'(MANT_W - 1 - i);
    end
    always_comb begin
        inc    = {1'b0, e2_q} + (EXP_W+1)'(1);
        shl    = (MANT_W-1)'(m2_q << lz2_q);
        zero_d = !c2_q && lz2_q == LZ_W'(MANT_W);
        ovf_d  = c2_q && inc >= (EXP_W+1)'((1 << EXP_W) - 1);
        unf_d  = !c2_q && !zero_d && CW'(lz2_q) >= CW'(e2_q);
        flip_d = f2_q && !zero_d;
        exp_d  = ovf_d ? '1 : zero_d || unf_d ? '0 : c2_q ? inc[EXP_W-1:0] : e2_q - EXP_W'(lz2_q);
        frac_d = zero_d || unf_d || ovf_d ? '0 : c2_q ? m2_q[MANT_W-1:1] : shl;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            m1_q   <= '0;
            m2_q   <= '0;
            f1_q   <= 1'b0;
            f2_q   <= 1'b0;
            c2_q   <= 1'b0;
            e1_q   <= '0;
            e2_q   <= '0;
            lz2_q  <= '0;
            frac_q <= '0;
            exp_q  <= '0;
            flip_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else if (adv) begin
            v1_q   <= bus.in_valid;
            m1_q   <= m1_d;
            f1_q   <= f1_d;
            e1_q   <= bus.exponent_temp;
            v2_q   <= v1_q;
            m2_q   <= m1_q[MANT_W-1:0];
            c2_q   <= m1_q[MANT_W];
            lz2_q  <= lz2_d;
            f2_q   <= f1_q;
            e2_q   <= e1_q;
            v3_q   <= v2_q;
            frac_q <= frac_d;
            exp_q  <= exp_d;
            flip_q <= flip_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end
endmodule

// File: tb/tb_fp_addsub_norm_pipe.sv
// tb_fp_addsub_norm_pipe: scenario tasks against an arithmetic reference model and an in-order scoreboard.
module tb_fp_addsub_norm_pipe;
    typedef struct packed {
        logic [22:0] frac;
        logic [7:0]  exp;
        logic        flip;
        logic        zero;
        logic        ovf;
        logic        unf;
    } res_t;
    typedef struct {
        res_t r;
        int   c;
    } item_t;
    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    item_t expq[$];
    item_t got[$];
    fp_addsub_norm_pipe_if bus();
    fp_addsub_norm_pipe dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic res_t model(input logic s, input logic [23:0] ns, input logic [23:0] sh, input logic [7:0] e);
        res_t  r;
        longint v;
        int    lz;
        r = '0;
        if (!s) v = longint'(ns) + longint'(sh);
        else if (sh > ns) begin v = longint'(sh) - longint'(ns); r.flip = 1'b1; end
        else v = longint'(ns) - longint'(sh);
        if (v == 0) begin
            r.zero = 1'b1;
            r.flip = 1'b0;
        end else if (v >= 64'd16777216) begin
            if (int'(e) + 1 >= 255) begin r.ovf = 1'b1; r.exp = 8'hFF; end
            else begin r.exp = 8'(int'(e) + 1); r.frac = 23'((v / 2) % 8388608); end
        end else begin
            lz = 0;
            while (v < 64'd8388608) begin v = v * 2; lz++; end
            if (lz >= int'(e)) r.unf = 1'b1;
            else begin r.exp = 8'(int'(e) - lz); r.frac = 23'(v - 8388608); end
        end
        return r;
    endfunction
    function automatic res_t out_now();
        return {bus.fraction, bus.exponent, bus.sign_flip, bus.zero, bus.overflow, bus.underflow};
    endfunction
    // Transfers are judged mid-low-phase, when both sides are settled for the coming edge.
    always @(negedge clk) begin
        item_t it;
        #2;
        if (rst) expq.delete();
        else begin
            if (bus.in_valid && bus.in_ready) begin
                it.r = model(bus.sel2, bus.nonShifted_val, bus.Shifted_val, bus.exponent_temp);
                it.c = cyc;
                expq.push_back(it);
            end
            if (bus.out_valid && bus.out_ready) begin
                it.r = out_now();
                it.c = cyc;
                got.push_back(it);
            end
        end
    end
    task automatic set_rand();
        int k;
        bus.sel2 = 1'($urandom);
        bus.nonShifted_val = ($urandom % 4 == 0) ? 24'($urandom) : 24'h800000 | 24'($urandom);
        k = int'($urandom_range(0, 25));
        bus.Shifted_val = 24'(((32'($urandom) & 32'hFFFFFF) | 32'h800000) >> k);
        if ($urandom % 8 == 0) bus.Shifted_val = bus.nonShifted_val;
        k = int'($urandom % 3);
        bus.exponent_temp = k == 0 ? 8'($urandom_range(0, 12)) : k == 1 ? 8'($urandom_range(245, 255)) : 8'($urandom);
    endtask
    task automatic send(input logic s, input logic [23:0] ns, input logic [23:0] sh, input logic [7:0] e);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.sel2 = s;
        bus.nonShifted_val = ns;
        bus.Shifted_val = sh;
        bus.exponent_temp = e;
        #2;
        while (!bus.in_ready && n < 50) begin @(negedge clk); #2; n++; end
        @(posedge clk);
    endtask
    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask
    task automatic wait_got(input int n);
        int k = 0;
        while (got.size() < n && k < 300) begin @(negedge clk); #3; k++; end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        tests++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
        tests++;
        if (out_now() !== res_t'(0)) begin fails++; $display("FAIL reset_outputs got=%h want=0", out_now()); end
        rst = 1'b0;
        @(negedge clk);
        #2;
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    endtask
    task automatic test_directed();
        logic        s  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [23:0] ns [6] = '{24'hC00000, 24'h400000, 24'h800000, 24'hABCDEF, 24'hFFFFFF, 24'd4560};
        logic [23:0] sh [6] = '{24'hC00000, 24'h800000, 24'h400000, 24'hABCDEF, 24'h000001, 24'd567};
        logic [7:0]  ex [6] = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd254, 8'd5};
        res_t want [6] = '{{23'h400000, 8'd101, 4'b0000}, {23'h0, 8'd99, 4'b1000}, {23'h0, 8'd99, 4'b0000},
                           {23'h0, 8'd0, 4'b0100}, {23'h0, 8'hFF, 4'b0010}, {23'h0, 8'd0, 4'b0001}};
        item_t g, e;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(s[i], ns[i], sh[i], ex[i]);
            idle();
            wait_got(1);
            tests++;
            if (got.size() != 1 || expq.size() != 1) begin
                fails++;
                $display("FAIL directed%0d_count got=%0d want=1", i, got.size());
                got.delete();
                expq.delete();
            end else begin
                g = got.pop_front();
                e = expq.pop_front();
                tests++;
                if (g.r !== want[i]) begin fails++; $display("FAIL directed%0d got=%h want=%h", i, g.r, want[i]); end
                tests++;
                if (g.c - e.c != 3) begin fails++; $display("FAIL directed%0d_latency got=%0d want=3", i, g.c - e.c); end
            end
        end
    endtask
    task automatic test_backpressure();
        int   acc = 0;
        logic fresh = 1'b1;
        res_t snap = '0;
        item_t g, e;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.out_ready = c >= 9;
            if (acc < 5) begin
                if (fresh) set_rand();
                bus.in_valid = 1'b1;
            end else bus.in_valid = 1'b0;
            #2;
            fresh = bus.in_valid && bus.in_ready;
            if (fresh) acc++;
            if (c == 6) begin
                tests++;
                if (acc != 3) begin fails++; $display("FAIL bp_accepted got=%0d want=3", acc); end
                tests++;
                if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got=%b want=0", bus.in_ready); end
                snap = out_now();
            end
            if (c == 8) begin
                tests++;
                if (bus.out_valid !== 1'b1 || out_now() !== snap)
                    begin fails++; $display("FAIL bp_stable got=%b/%h want=1/%h", bus.out_valid, out_now(), snap); end
            end
        end
        bus.in_valid = 1'b0;
        wait_got(5);
        tests++;
        if (got.size() != 5 || expq.size() != 5) begin fails++; $display("FAIL bp_count got=%0d want=5", got.size()); end
        while (got.size() > 0 && expq.size() > 0) begin
            g = got.pop_front();
            e = expq.pop_front();
            tests++;
            if (g.r !== e.r) begin fails++; $display("FAIL bp_data got=%h want=%h", g.r, e.r); end
        end
        got.delete();
        expq.delete();
    endtask
    task automatic test_stream();
        item_t g, e;
        int first = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            set_rand();
            bus.in_valid = 1'b1;
            #2;
            tests++;
            if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready beat %0d got=0 want=1", i); end
        end
        idle();
        wait_got(20);
        tests++;
        if (got.size() != 20 || expq.size() != 20) begin fails++; $display("FAIL stream_count got=%0d want=20", got.size()); end
        for (int i = 0; got.size() > 0 && expq.size() > 0; i++) begin
            g = got.pop_front();
            e = expq.pop_front();
            if (i == 0) first = g.c;
            tests++;
            if (g.r !== e.r) begin fails++; $display("FAIL stream_data %0d got=%h want=%h", i, g.r, e.r); end
            tests++;
            if (g.c - e.c != 3 || g.c != first + i)
                begin fails++; $display("FAIL stream_timing %0d got=%0d want=3", i, g.c - e.c); end
        end
        got.delete();
        expq.delete();
    endtask
    task automatic test_random();
        int n;
        item_t g, e;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            set_rand();
            bus.in_valid = ($urandom % 4) != 0;
            bus.out_ready = ($urandom % 3) != 0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        n = expq.size();
        wait_got(n);
        tests++;
        if (got.size() != n) begin fails++; $display("FAIL random_count got=%0d want=%0d", got.size(), n); end
        while (got.size() > 0 && expq.size() > 0) begin
            g = got.pop_front();
            e = expq.pop_front();
            tests++;
            if (g.r !== e.r) begin fails++; $display("FAIL random_data got=%h want=%h", g.r, e.r); end
        end
        got.delete();
        expq.delete();
    endtask
    task automatic test_mid_reset();
        bus.out_ready = 1'b1;
        send(1'b0, 24'hC00000, 24'h400000, 8'd50);
        idle();
        wait_got(1);
        got.delete();
        expq.delete();
        send(1'b0, 24'h900000, 24'h123456, 8'd77);
        send(1'b1, 24'hF00000, 24'h0F0F0F, 8'd120);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        tests++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got=%b want=0", bus.out_valid); end
        tests++;
        if (out_now() !== res_t'(0)) begin fails++; $display("FAIL midrst_outputs got=%h want=0", out_now()); end
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready got=%b want=1", bus.in_ready); end
        repeat (10) @(negedge clk);
        #3;
        tests++;
        if (got.size() != 0) begin fails++; $display("FAIL midrst_stale got=%0d want=0", got.size()); end
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.sel2 = 1'b0;
        bus.Shifted_val = '0;
        bus.nonShifted_val = '0;
        bus.exponent_temp = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_stream();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
